// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: ACE snoop endpoint; one AC snoop at a time, CR + CD reply, cache state update.
// Optional perf counters are built when ACE_SNOOP_PERF_CNT_EN is defined.
module ace_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned DataBeats = 4,
    parameter type snoop_req_t = struct packed {
        logic ac_valid;
        struct packed {
            logic [AddrWidth-1:0] addr;
            logic [2:0]           prot;
            logic [3:0]           snoop;
        } ac;
        logic cr_ready;
        logic cd_ready;
    },
    parameter type snoop_resp_t = struct packed {
        logic ac_ready;
        logic cr_valid;
        struct packed {
            logic dataTransfer;
            logic error;
            logic passDirty;
            logic isShared;
            logic wasUnique;
        } cr_resp;
        logic cd_valid;
        struct packed {
            logic [DataWidth-1:0] data;
            logic                 last;
        } cd;
    },
    localparam int unsigned BeatWidth = (DataBeats > 1) ? $clog2(DataBeats) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  snoop_req_t           snoop_req_i,
    output snoop_resp_t          snoop_resp_o,
    output logic                 lookup_req_o,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_gnt_i,
    input  logic                 lookup_valid_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_dirty_i,
    input  logic                 lookup_shared_i,
    output logic                 data_req_o,
    output logic [BeatWidth-1:0] data_beat_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 upd_valid_o,
    output logic                 upd_invalidate_o,
    output logic                 upd_clean_o,
    output logic                 upd_shared_o,
    output logic [31:0]          perf_snoops_o,
    output logic [31:0]          perf_hits_o,
    output logic [31:0]          perf_beats_o
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WAIT_LKP, SEND_CR, READ_DATA, SEND_CD, UPDATE
    } state_e;

    state_e               state, state_next;
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic                 hit, dirty, shared;
    logic [BeatWidth-1:0] beat;
    logic [DataWidth-1:0] data_hold, cd_data;
    logic                 first_beat;
    logic                 ac_hs, lkp_take, cd_hs, last_beat;
    logic                 supported, dt, pd, is_shared, need_upd;
    logic                 act_inv, act_clean, act_shared;
    logic                 unused_prot;

    assign ac_hs       = (state == IDLE) & snoop_req_i.ac_valid;
    assign lkp_take    = lookup_valid_i
                       & (((state == LOOKUP) & lookup_gnt_i) | (state == WAIT_LKP));
    assign cd_hs       = (state == SEND_CD) & snoop_req_i.cd_ready;
    assign last_beat   = (beat == BeatWidth'(DataBeats - 1));
    // read data is only present on data_i in the first SEND_CD cycle; hold it afterwards
    assign cd_data     = first_beat ? data_i : data_hold;
    assign unused_prot = ^snoop_req_i.ac.prot;

    assign lookup_addr_o = addr;
    assign data_beat_o   = beat;

    // Decode the CR response and cache update from the captured snoop and line state
    always_comb begin
        supported  = 1'b1;
        dt         = 1'b0;
        pd         = 1'b0;
        is_shared  = 1'b0;
        need_upd   = 1'b0;
        act_inv    = 1'b0;
        act_clean  = 1'b0;
        act_shared = 1'b0;
        unique case (snoop)
            4'b0000: begin
                dt        = 1'b1;
                is_shared = 1'b1;
            end
            4'b0001, 4'b0010: begin
                dt         = 1'b1;
                pd         = dirty;
                is_shared  = 1'b1;
                need_upd   = 1'b1;
                act_clean  = dirty;
                act_shared = 1'b1;
            end
            4'b0111: begin
                dt       = 1'b1;
                pd       = dirty;
                need_upd = 1'b1;
                act_inv  = 1'b1;
            end
            4'b1001: begin
                dt       = dirty;
                pd       = dirty;
                need_upd = 1'b1;
                act_inv  = 1'b1;
            end
            4'b1101: begin
                need_upd = 1'b1;
                act_inv  = 1'b1;
            end
            default: supported = 1'b0;
        endcase
        if (!hit) begin
            dt         = 1'b0;
            pd         = 1'b0;
            is_shared  = 1'b0;
            need_upd   = 1'b0;
            act_inv    = 1'b0;
            act_clean  = 1'b0;
            act_shared = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (ac_hs) state_next = LOOKUP;
            LOOKUP:    if (lookup_gnt_i)
                           state_next = lookup_valid_i ? SEND_CR : WAIT_LKP;
            WAIT_LKP:  if (lookup_valid_i) state_next = SEND_CR;
            SEND_CR:   if (snoop_req_i.cr_ready)
                           state_next = dt ? READ_DATA : (need_upd ? UPDATE : IDLE);
            READ_DATA: state_next = SEND_CD;
            SEND_CD:   if (snoop_req_i.cd_ready)
                           state_next = !last_beat ? READ_DATA : (need_upd ? UPDATE : IDLE);
            UPDATE:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        snoop_resp_o     = '0;
        lookup_req_o     = 1'b0;
        data_req_o       = 1'b0;
        upd_valid_o      = 1'b0;
        upd_invalidate_o = 1'b0;
        upd_clean_o      = 1'b0;
        upd_shared_o     = 1'b0;
        unique case (state)
            IDLE:      snoop_resp_o.ac_ready = 1'b1;
            LOOKUP:    lookup_req_o = 1'b1;
            SEND_CR: begin
                snoop_resp_o.cr_valid             = 1'b1;
                snoop_resp_o.cr_resp.dataTransfer = dt;
                snoop_resp_o.cr_resp.error        = ~supported;
                snoop_resp_o.cr_resp.passDirty    = pd;
                snoop_resp_o.cr_resp.isShared     = is_shared;
                snoop_resp_o.cr_resp.wasUnique    = supported & hit & ~shared;
            end
            READ_DATA: data_req_o = 1'b1;
            SEND_CD: begin
                snoop_resp_o.cd_valid = 1'b1;
                snoop_resp_o.cd.data  = cd_data;
                snoop_resp_o.cd.last  = last_beat;
            end
            UPDATE: begin
                upd_valid_o      = 1'b1;
                upd_invalidate_o = act_inv;
                upd_clean_o      = act_clean;
                upd_shared_o     = act_shared;
            end
            default: ;
        endcase
    end

    // Capture snoop request, lookup result, beat index and read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr       <= '0;
            snoop      <= '0;
            hit        <= 1'b0;
            dirty      <= 1'b0;
            shared     <= 1'b0;
            beat       <= '0;
            data_hold  <= '0;
            first_beat <= 1'b0;
        end else begin
            first_beat <= (state == READ_DATA);
            if (ac_hs) begin
                addr  <= AddrWidth'(snoop_req_i.ac.addr);
                snoop <= snoop_req_i.ac.snoop;
            end
            if (lkp_take) begin
                hit    <= lookup_hit_i;
                dirty  <= lookup_dirty_i;
                shared <= lookup_shared_i;
            end
            if (first_beat) data_hold <= data_i;
            if (cd_hs)      beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

`ifdef ACE_SNOOP_PERF_CNT_EN
    logic [31:0] cnt_snoops, cnt_hits, cnt_beats;

    // Wrapping event counters for snoops, hits and CD beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_snoops <= '0;
            cnt_hits   <= '0;
            cnt_beats  <= '0;
        end else begin
            if (ac_hs)                   cnt_snoops <= cnt_snoops + 32'd1;
            if (lkp_take & lookup_hit_i) cnt_hits   <= cnt_hits + 32'd1;
            if (cd_hs)                   cnt_beats  <= cnt_beats + 32'd1;
        end
    end

    assign perf_snoops_o = cnt_snoops;
    assign perf_hits_o   = cnt_hits;
    assign perf_beats_o  = cnt_beats;
`else
    assign perf_snoops_o = '0;
    assign perf_hits_o   = '0;
    assign perf_beats_o  = '0;
`endif

endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed snoop vectors against ace_snoop_responder.
// Counter expectations follow ACE_SNOOP_PERF_CNT_EN.
module tb_ace_snoop_responder;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  prot;
        logic [3:0]  snoop;
    } ac_t;
    typedef struct packed {
        logic ac_valid;
        ac_t  ac;
        logic cr_ready;
        logic cd_ready;
    } req_t;
    typedef struct packed {
        logic dataTransfer;
        logic error;
        logic passDirty;
        logic isShared;
        logic wasUnique;
    } cr_t;
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_t;
    typedef struct packed {
        logic ac_ready;
        logic cr_valid;
        cr_t  cr_resp;
        logic cd_valid;
        cd_t  cd;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    req_t        req;
    resp_t       resp;
    logic        lookup_req, lookup_gnt, lookup_valid;
    logic        cfg_hit = 1'b0, cfg_dirty = 1'b0, cfg_shared = 1'b0;
    logic [63:0] lookup_addr;
    logic        data_req;
    logic [1:0]  data_beat;
    logic [63:0] data = '0;
    logic        upd_valid, upd_inv, upd_clean, upd_shared;
    logic [31:0] perf_snoops, perf_hits, perf_beats;
    logic        lkp_delay = 1'b0, lkp_pend = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [4:0]  rec_resp;
    int          cr_cnt, cr_hs, cr_hs_cyc, cr_cyc, lkp_cyc, cr_unstable;
    int          nbeats, stalls, cd_unstable, upd_cnt, idle_cyc;
    logic [2:0]  upd_bits;
    logic [7:0]  last_mask;
    logic [63:0] beats [8];

    always #5 clk = ~clk;

    assign lookup_gnt   = lookup_req;
    assign lookup_valid = lkp_delay ? lkp_pend : lookup_req;

    function automatic logic [63:0] word(input int b);
        return 64'hC0FF_EE00_0000_0000 + 64'(b * 32'h0101_0001);
    endfunction

    function automatic logic [4:0] pack(input resp_t r);
        return {r.cr_resp.dataTransfer, r.cr_resp.error, r.cr_resp.passDirty,
                r.cr_resp.isShared, r.cr_resp.wasUnique};
    endfunction

    // Cache model: one-cycle read latency, garbage when no read is issued
    always @(posedge clk) begin
        lkp_pend <= lookup_req & ~lkp_pend;
        data     <= data_req ? word(int'(data_beat)) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    ace_snoop_responder #(
        .AddrWidth   (64),
        .DataWidth   (64),
        .DataBeats   (4),
        .snoop_req_t (req_t),
        .snoop_resp_t(resp_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .snoop_req_i     (req),
        .snoop_resp_o    (resp),
        .lookup_req_o    (lookup_req),
        .lookup_addr_o   (lookup_addr),
        .lookup_gnt_i    (lookup_gnt),
        .lookup_valid_i  (lookup_valid),
        .lookup_hit_i    (cfg_hit),
        .lookup_dirty_i  (cfg_dirty),
        .lookup_shared_i (cfg_shared),
        .data_req_o      (data_req),
        .data_beat_o     (data_beat),
        .data_i          (data),
        .upd_valid_o     (upd_valid),
        .upd_invalidate_o(upd_inv),
        .upd_clean_o     (upd_clean),
        .upd_shared_o    (upd_shared),
        .perf_snoops_o   (perf_snoops),
        .perf_hits_o     (perf_hits),
        .perf_beats_o    (perf_beats)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_snoop(input logic [3:0] code, input logic h, input logic d,
                             input logic s, input int stall, input bit toggle);
        int   cr_wait;
        logic cd_stalled;
        logic [63:0] prev_data;
        cfg_hit = h; cfg_dirty = d; cfg_shared = s;
        rec_resp = 'x; cr_cnt = 0; cr_hs = 0; cr_hs_cyc = -1; cr_cyc = -1;
        lkp_cyc = -1; cr_unstable = 0; nbeats = 0; stalls = 0; cd_unstable = 0;
        upd_cnt = 0; idle_cyc = -1; upd_bits = 'x; last_mask = '0;
        cr_wait = 0; cd_stalled = 1'b0; prev_data = '0;
        @(negedge clk);
        req.ac_valid = 1'b1;
        req.ac.addr  = 64'h8000_1040;
        req.ac.prot  = 3'b010;
        req.ac.snoop = code;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) begin
                req.ac_valid = 1'b0;
                if (resp.ac_ready) begin
                    idle_cyc = cyc;
                    break;
                end
            end
            if (lookup_req && lkp_cyc < 0) lkp_cyc = cyc;
            req.cr_ready = (cr_wait >= stall);
            if (resp.cr_valid) begin
                cr_cnt++;
                if (cr_cyc < 0) begin
                    cr_cyc   = cyc;
                    rec_resp = pack(resp);
                end else if (pack(resp) !== rec_resp) cr_unstable++;
                cr_wait++;
                if (req.cr_ready) begin
                    cr_hs++;
                    cr_hs_cyc = cyc;
                end
            end
            req.cd_ready = toggle ? cyc[1] : 1'b1;
            if (resp.cd_valid) begin
                if (cd_stalled && resp.cd.data !== prev_data) cd_unstable++;
                prev_data  = resp.cd.data;
                cd_stalled = !req.cd_ready;
                if (!req.cd_ready) stalls++;
                else begin
                    if (nbeats < 8) begin
                        beats[nbeats] = resp.cd.data;
                        if (resp.cd.last) last_mask[nbeats] = 1'b1;
                    end
                    nbeats++;
                end
            end else cd_stalled = 1'b0;
            if (upd_valid) begin
                upd_cnt++;
                upd_bits = {upd_inv, upd_clean, upd_shared};
            end
            @(negedge clk);
        end
        req.cr_ready = 1'b0;
        req.cd_ready = 1'b0;
    endtask

    task automatic check_run(input string t, input logic [4:0] resp_exp, input int beats_exp,
                             input int upd_exp, input logic [2:0] bits_exp);
        check({t, "_idle"}, 64'(idle_cyc >= 0), 1);
        check({t, "_cr_hs"}, cr_hs, 1);
        check({t, "_cr_resp"}, rec_resp, resp_exp);
        check({t, "_cr_stable"}, cr_unstable, 0);
        check({t, "_beats"}, nbeats, beats_exp);
        for (int i = 0; i < beats_exp; i++)
            check($sformatf("%s_data%0d", t, i), beats[i], word(i));
        check({t, "_last"}, last_mask, (beats_exp > 0) ? 64'(1 << (beats_exp - 1)) : 64'h0);
        check({t, "_cd_stable"}, cd_unstable, 0);
        check({t, "_upd_cnt"}, upd_cnt, upd_exp);
        if (upd_exp > 0) check({t, "_upd_bits"}, upd_bits, bits_exp);
    endtask

    initial begin
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ac_ready", resp.ac_ready, 1);
        check("rst_valids", {resp.cr_valid, resp.cd_valid, upd_valid, lookup_req, data_req}, 0);
        check("rst_perf", {perf_snoops, perf_hits} | 64'(perf_beats), 0);

        // ReadShared, hit dirty unique: DT PD IS WU, clean+shared update
        run_snoop(4'b0001, 1, 1, 0, 0, 0);
        check_run("rd_shared", 5'b10111, 4, 1, 3'b011);
        check("rd_shared_lkp_cyc", lkp_cyc, 1);
        check("rd_shared_cr_cyc", cr_cyc, 2);
        check("rd_shared_done_cyc", idle_cyc, 12);

        // ReadUnique, hit clean unique, CD backpressure
        run_snoop(4'b0111, 1, 0, 0, 0, 1);
        check_run("rd_unique", 5'b10001, 4, 1, 3'b100);
        check("rd_unique_stalled", 64'(stalls > 0), 1);

        // CleanInvalid miss: all-zero CR, straight back to IDLE
        run_snoop(4'b1001, 0, 1, 0, 0, 0);
        check_run("cln_inv_miss", 5'b00000, 0, 0, 3'b000);
        check("cln_inv_idle_next", idle_cyc, cr_hs_cyc + 1);

`ifdef ACE_SNOOP_PERF_CNT_EN
        check("perf_snoops", perf_snoops, 3);
        check("perf_hits", perf_hits, 2);
        check("perf_beats", perf_beats, 8);
`else
        check("perf_snoops", perf_snoops, 0);
        check("perf_hits", perf_hits, 0);
        check("perf_beats", perf_beats, 0);
`endif

        // Unsupported snoop 0011 on a hit: error only
        run_snoop(4'b0011, 1, 1, 0, 0, 0);
        check_run("unsupported", 5'b01000, 0, 0, 3'b000);

        // ReadOnce, hit shared, cr_ready low for 5 cycles
        run_snoop(4'b0000, 1, 0, 1, 5, 0);
        check_run("rd_once_stall", 5'b10010, 4, 0, 3'b000);
        check("rd_once_cr_cycles", cr_cnt, 6);

        // MakeInvalid with lookup result one cycle after grant
        lkp_delay = 1'b1;
        run_snoop(4'b1101, 1, 1, 0, 0, 0);
        lkp_delay = 1'b0;
        check_run("mk_inv_wait", 5'b00001, 0, 1, 3'b100);
        check("mk_inv_cr_cyc", cr_cyc, 3);

        // ReadClean, hit clean shared
        run_snoop(4'b0010, 1, 0, 1, 0, 0);
        check_run("rd_clean", 5'b10010, 4, 1, 3'b001);

        // Reset asserted while a CD beat is stalled
        cfg_hit = 1'b1; cfg_dirty = 1'b1; cfg_shared = 1'b0;
        @(negedge clk);
        req.ac_valid = 1'b1;
        req.ac.snoop = 4'b0001;
        for (int cyc = 0; cyc < 50 && !resp.cd_valid; cyc++) begin
            @(negedge clk);
            req.ac_valid = 1'b0;
            req.cr_ready = 1'b1;
            req.cd_ready = 1'b0;
        end
        req.cr_ready = 1'b0;
        check("rst_mid_reached_cd", resp.cd_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valids", {resp.cr_valid, resp.cd_valid, upd_valid, lookup_req, data_req}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", resp.ac_ready, 1);
        check("rst_mid_perf", {perf_snoops, perf_hits} | 64'(perf_beats), 0);

        // Recovery after reset: beats restart at 0
        run_snoop(4'b0001, 1, 0, 0, 0, 0);
        check_run("post_rst", 5'b10011, 4, 1, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
